icache_ctrl: RTL and testbench

Direct-mapped instruction-cache controller between the fetch stage and `inst_mem`. It serves 32-bit instruction fetches from a local array of 128-bit lines and stalls fetch on a miss. On a miss it drives a line-aligned address into `inst_mem`, waits out the memory's registered read latency, and fills the line. It also keeps saturating hit and miss counters for performance runs.

---
 rtl/icache_ctrl.sv | 148 ++++++++++++++
 tb/tb_icache_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 128-bit lines, blocking miss refill
// from a fixed-latency inst_mem, and saturating hit/miss counters.
module icache_ctrl #(
  parameter int unsigned LINES       = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pc_valid,
  input  logic [31:0]  pc,
  input  logic         flush,
  output logic [31:0]  inst,
  output logic         inst_valid,
  output logic         stall,
  output logic [31:0]  mem_address,
  input  logic [127:0] mem_dataline,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int unsigned IDX   = $clog2(LINES);
  localparam int unsigned TAG_W = 28 - IDX;
  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic {LOOKUP, MISS} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem_address_q, mem_address_d;
  logic [31:0]        hit_count_q, hit_count_d;
  logic [31:0]        miss_count_q, miss_count_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];
  logic               fill_en;

  logic [IDX-1:0]     req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic [127:0]       hit_line;
  logic [31:0]        hit_word;
  logic               hit_c;
  logic               unused_c;

  assign req_idx  = pc[3+IDX:4];
  assign req_tag  = pc[31:4+IDX];
  assign fill_idx = mem_address_q[3+IDX:4];
  assign fill_tag = mem_address_q[31:4+IDX];
  assign hit_line = data_q[req_idx];
  assign hit_c    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_c = ^pc[1:0];

  assign mem_address = mem_address_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

  // Word 0 sits in the MSBs of the line.
  always_comb begin
    hit_word = hit_line[127:96];
    case (pc[3:2])
      2'd0:    hit_word = hit_line[127:96];
      2'd1:    hit_word = hit_line[95:64];
      2'd2:    hit_word = hit_line[63:32];
      default: hit_word = hit_line[31:0];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_address_d = mem_address_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    valid_d       = valid_q;
    fill_en       = 1'b0;
    inst          = 32'h0;
    inst_valid    = 1'b0;
    stall         = 1'b0;

    case (state_q)
      LOOKUP: begin
        if (flush) begin
          valid_d = '0;
          stall   = pc_valid;
        end else if (pc_valid) begin
          if (hit_c) begin
            inst        = hit_word;
            inst_valid  = 1'b1;
            hit_count_d = (hit_count_q != 32'hFFFF_FFFF) ? hit_count_q + 32'd1 : hit_count_q;
          end else begin
            stall         = 1'b1;
            mem_address_d = {pc[31:4], 4'b0000};
            cnt_d         = CNT_W'(MEM_LATENCY);
            miss_count_d  = (miss_count_q != 32'hFFFF_FFFF) ? miss_count_q + 32'd1 : miss_count_q;
            state_d       = MISS;
          end
        end
      end
      MISS: begin
        stall = 1'b1;
        // A flush during refill drops the pending line entirely.
        if (flush) begin
          valid_d = '0;
          state_d = LOOKUP;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          fill_en           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = LOOKUP;
        end
      end
      default: state_d = LOOKUP;
    endcase

    if (reset) begin
      inst       = 32'h0;
      inst_valid = 1'b0;
      stall      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= LOOKUP;
      cnt_q         <= '0;
      mem_address_q <= 32'h0;
      hit_count_q   <= 32'h0;
      miss_count_q  <= 32'h0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
      valid_q       <= valid_d;
    end
  end

  // Tag and data arrays need no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_dataline;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: directed fetches push expected instructions,
// a negedge monitor pops and compares whenever inst_valid is presented.
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         pc_valid;
  logic [31:0]  pc;
  logic         flush;
  logic [31:0]  inst;
  logic         inst_valid;
  logic         stall;
  logic [31:0]  mem_address;
  logic [127:0] mem_dataline = '0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] exp_hits;
  logic [31:0] exp_misses;

  icache_ctrl #(.LINES(16), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .pc_valid(pc_valid), .pc(pc), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .stall(stall),
    .mem_address(mem_address), .mem_dataline(mem_dataline),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] line_data(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'hF;
    return {32'hA000_0000 | b, 32'hA000_0000 | (b + 32'd4),
            32'hA000_0000 | (b + 32'd8), 32'hA000_0000 | (b + 32'd12)};
  endfunction

  // Behavioural inst_mem: one registered edge of latency.
  always @(posedge clk) mem_dataline <= line_data(mem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: got %h expected nothing at %0t", inst, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("inst", inst, mon_exp);
        end
      end else begin
        check("inst_idle_zero", inst, 32'h0);
      end
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One fetch; a miss must stall for MEM_LATENCY+2 cycles and then hit.
  task automatic fetch(input logic [31:0] a, input bit miss);
    int n;
    @(posedge clk); #1;
    pc = a; pc_valid = 1'b1; flush = 1'b0;
    exp_q.push_back(32'hA000_0000 | (a & ~32'h3));
    n = 0;
    @(negedge clk);
    if (miss) begin
      while (stall === 1'b1 && n < 20) begin
        n++;
        if (n >= 2) check("mem_address", mem_address, a & ~32'hF);
        @(negedge clk);
      end
      check("miss_penalty", 32'(n), 32'd3);
      exp_misses = sat_inc(exp_misses);
      check("miss_count", miss_count, exp_misses);
    end else begin
      check("hit_no_stall", {31'b0, stall}, 32'd0);
    end
    check("hit_count", hit_count, exp_hits);
    exp_hits = sat_inc(exp_hits);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pc_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pc = 32'h24; pc_valid = 1'b1; flush = 1'b0;
    exp_hits = 32'h0; exp_misses = 32'h0;
    #12;
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("reset_inst", inst, 32'h0);
    check("reset_mem_address", mem_address, 32'h0);
    check("reset_counters", hit_count | miss_count, 32'h0);
    @(negedge clk);
    reset = 1'b0; pc_valid = 1'b0;

    // Cold miss then spatial hits in the same line.
    fetch(32'h24, 1'b1);
    fetch(32'h20, 1'b0);
    fetch(32'h28, 1'b0);
    fetch(32'h2C, 1'b0);
    idle();

    // Single-cycle flush with a live request, then refetch misses.
    @(posedge clk); #1;
    pc = 32'h20; pc_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("flush_stall", {31'b0, stall}, 32'd1);
    fetch(32'h20, 1'b1);
    idle();

    // Flush in the second MISS cycle aborts the fill.
    @(posedge clk); #1;
    pc = 32'h40; pc_valid = 1'b1; flush = 1'b0;
    exp_misses = sat_inc(exp_misses);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_miss_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; pc_valid = 1'b0;
    @(negedge clk);
    check("flush_miss_count", miss_count, exp_misses);
    fetch(32'h40, 1'b1);
    idle();

    // Asynchronous reset in the middle of a miss.
    @(posedge clk); #1;
    pc = 32'h80; pc_valid = 1'b1;
    @(posedge clk); #1;
    #1 reset = 1'b1;
    #1;
    check("amid_reset_stall", {31'b0, stall}, 32'd0);
    check("amid_reset_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("amid_reset_inst", inst, 32'h0);
    check("amid_reset_mem_address", mem_address, 32'h0);
    check("amid_reset_hit_count", hit_count, 32'h0);
    check("amid_reset_miss_count", miss_count, 32'h0);
    pc_valid = 1'b0;
    exp_hits = 32'h0; exp_misses = 32'h0;
    #1 reset = 1'b0;
    fetch(32'h80, 1'b1);
    fetch(32'h20, 1'b1);

    // Conflict eviction on index 2.
    fetch(32'h24, 1'b0);
    fetch(32'h124, 1'b1);
    fetch(32'h24, 1'b1);
    check("conflict_miss_count", miss_count, 32'd4);
    idle();

    // Hit counter saturation.
    @(negedge clk);
    force dut.hit_count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.hit_count_q;
    exp_hits = 32'hFFFF_FFFE;
    fetch(32'h24, 1'b0);
    fetch(32'h28, 1'b0);
    fetch(32'h2C, 1'b0);
    idle();
    @(negedge clk);
    check("hit_count_saturated", hit_count, 32'hFFFF_FFFF);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
